// File: rtl/mcc_sequencer.sv
// mcc_sequencer: multi-cycle control FSM with ready handshakes, illegal-opcode/timeout TRAP and HALT.
// Optional MCC_PERF_CNT_EN adds cycle_count/instr_count performance counters.
module mcc_sequencer #(
  parameter int ALUOP_W = 4,
  parameter int MEM_TIMEOUT = 15
`ifdef MCC_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         opcode,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_to_reg,
  output logic               mem_read_not_write,
  output logic               mem_select,
  output logic               reg_write,
  output logic               halted,
  output logic               trap,
  output logic [2:0]         state
`ifdef MCC_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0]   instr_count
`endif
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;
  localparam logic [4:0] OP_NOP = 5'h00, OP_LOAD = 5'h18, OP_STORE = 5'h19;
  localparam logic [4:0] OP_BEQ = 5'h1A, OP_JUMP = 5'h1B, OP_HALT = 5'h1F;
  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'(MEM_TIMEOUT - 1);
  state_t         r_state, w_next;
  logic [WCW-1:0] r_wait;
  logic           w_rtype, w_itype, w_load, w_beq, w_mem_op, w_illegal;
  logic           w_stall, w_timeout;
  assign w_rtype   = !opcode[4] && (opcode != OP_NOP);
  assign w_itype   = opcode[4:3] == 2'b10;
  assign w_load    = opcode == OP_LOAD;
  assign w_beq     = opcode == OP_BEQ;
  assign w_mem_op  = w_load || (opcode == OP_STORE);
  assign w_illegal = (opcode == 5'h1C) || (opcode == 5'h1D) || (opcode == 5'h1E);
  assign w_stall   = reset && (((r_state == S_FETCH) && !imem_ready) || ((r_state == S_MEM) && !dmem_ready));
  assign w_timeout = r_wait == WLIM;
  assign state     = reset ? r_state : S_FETCH;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_stall && !w_timeout) ? r_wait + 1'b1 : '0;
    end
  end
  always_comb begin
    w_next             = r_state;
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    pc_source          = 2'd0;
    alu_src_a          = 1'b0;
    alu_src_b          = 2'd0;
    alu_op             = '0;
    mem_to_reg         = 1'b0;
    mem_read_not_write = 1'b0;
    mem_select         = 1'b0;
    reg_write          = 1'b0;
    halted             = 1'b0;
    trap               = 1'b0;
    if (!reset) begin
      pc_write  = 1'b1;
      pc_source = 2'd3;
    end else begin
      case (r_state)
        S_FETCH: begin
          alu_src_b = 2'd1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else if (w_timeout) begin
            w_next = S_TRAP;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd2;
          if (opcode == OP_NOP) w_next = S_FETCH;
          else if (opcode == OP_HALT) w_next = S_HALT;
          else if (w_illegal) w_next = S_TRAP;
          else if (opcode == OP_JUMP) begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            w_next    = S_FETCH;
          end else w_next = S_EXEC;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = (w_rtype || w_beq) ? 2'd0 : 2'd2;
          alu_op    = w_rtype ? ALUOP_W'(opcode[3:0]) : w_itype ? ALUOP_W'(opcode[2:0]) : w_beq ? ALUOP_W'(1) : '0;
          pc_write  = w_beq && zero;
          pc_source = (w_beq && zero) ? 2'd1 : 2'd0;
          w_next    = w_mem_op ? S_MEM : (w_rtype || w_itype) ? S_WB : S_FETCH;
        end
        S_MEM: begin
          mem_select         = 1'b1;
          mem_read_not_write = w_load;
          if (dmem_ready) w_next = w_load ? S_WB : S_FETCH;
          else if (w_timeout) w_next = S_TRAP;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = w_load;
          w_next     = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        S_TRAP: trap = 1'b1;
        default: w_next = S_FETCH;
      endcase
    end
  end
`ifdef MCC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cyc, r_ins;
  assign cycle_count = r_cyc;
  assign instr_count = r_ins;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      if ((r_state != S_HALT) && (r_state != S_TRAP)) r_cyc <= r_cyc + 1'b1;
      if ((w_next == S_FETCH) && (r_state != S_FETCH)) r_ins <= r_ins + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mcc_sequencer.sv
// tb_mcc_sequencer: directed spec scenarios plus randomized traffic, checked every cycle
// against a path-per-opcode-class reference model.
module tb_mcc_sequencer;
  localparam int TO = 15;
  logic       clock = 1'b0, reset = 1'b0, zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [4:0] opcode = '0;
  logic       ir_write, pc_write, alu_src_a, mem_to_reg, mem_read_not_write, mem_select;
  logic       reg_write, halted, trap;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] state;
`ifdef MCC_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count, m_cyc = 0, m_ins = 0;
`endif
  int n_chk = 0, n_err = 0;
  int m_pos = 0, m_wait = 0, m_dead = 0;
  logic [31:0] g_state, g_ms, g_rnw, g_m2r, g_pcw, g_pcs, g_rw, g_aluop, g_halt, g_trap;

  mcc_sequencer dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .mem_read_not_write(mem_read_not_write),
    .mem_select(mem_select), .reg_write(reg_write), .halted(halted),
    .trap(trap), .state(state)
`ifdef MCC_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Sequence of states an instruction walks through when every ready is high; -1 past the end.
  function automatic int pat(input logic [4:0] op, input int i);
    int q[$];
    if (op == 5'h00 || op == 5'h1B) q = '{0, 1};
    else if (op == 5'h1A) q = '{0, 1, 2};
    else if (op == 5'h18) q = '{0, 1, 2, 3, 4};
    else if (op == 5'h19) q = '{0, 1, 2, 3};
    else if (op == 5'h1F) q = '{0, 1, 5};
    else if (op >= 5'h1C) q = '{0, 1, 6};
    else q = '{0, 1, 2, 4};
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int mstate();
    return (m_dead != 0) ? m_dead : pat(opcode, m_pos);
  endfunction

  task automatic compare();
    int s;
    logic [4:0] op;
    bit r, rt, it, bq, ld, jp, tk;
    op = opcode;
    s  = mstate();
    r  = reset;
    rt = (op >= 5'h01) && (op <= 5'h0F);
    it = (op >= 5'h10) && (op <= 5'h17);
    bq = op == 5'h1A;
    ld = op == 5'h18;
    jp = op == 5'h1B;
    tk = r && s == 2 && bq && zero;
    chk("ir_write", ir_write, r && s == 0 && imem_ready);
    chk("pc_write", pc_write, !r || (s == 0 && imem_ready) || (s == 1 && jp) || tk);
    chk("pc_source", pc_source, !r ? 3 : (s == 1 && jp) ? 2 : tk ? 1 : 0);
    chk("alu_src_a", alu_src_a, r && s == 2);
    chk("alu_src_b", alu_src_b, !r ? 0 : s == 0 ? 1 : s == 1 ? 2 : (s == 2 && !rt && !bq) ? 2 : 0);
    chk("alu_op", alu_op, (!r || s != 2) ? 0 : rt ? op % 16 : it ? op % 8 : bq ? 1 : 0);
    chk("mem_to_reg", mem_to_reg, r && s == 4 && ld);
    chk("mem_rnw", mem_read_not_write, r && s == 3 && ld);
    chk("mem_select", mem_select, r && s == 3);
    chk("reg_write", reg_write, r && s == 4);
    chk("halted", halted, r && s == 5);
    chk("trap", trap, r && s == 6);
    chk("state", state, r ? s : 0);
`ifdef MCC_PERF_CNT_EN
    chk("cycle_count", cycle_count, m_cyc);
    chk("instr_count", instr_count, m_ins);
`endif
  endtask

  task automatic advance();
    int s, nx;
    if (!reset) begin
      m_pos = 0; m_wait = 0; m_dead = 0;
`ifdef MCC_PERF_CNT_EN
      m_cyc = 0; m_ins = 0;
`endif
    end else if (m_dead == 0) begin
`ifdef MCC_PERF_CNT_EN
      m_cyc++;
`endif
      s = pat(opcode, m_pos);
      if ((s == 0 && !imem_ready) || (s == 3 && !dmem_ready)) begin
        if (m_wait == TO - 1) m_dead = 6;
        else m_wait++;
      end else begin
        m_wait = 0;
        nx = pat(opcode, m_pos + 1);
        if (nx < 0) begin
          m_pos = 0;
`ifdef MCC_PERF_CNT_EN
          m_ins++;
`endif
        end else if (nx >= 5) m_dead = nx;
        else m_pos++;
      end
    end
  endtask

  task automatic cyc(input bit r, input logic [4:0] op, input bit im, input bit dm, input bit z);
    reset = r; opcode = op; imem_ready = im; dmem_ready = dm; zero = z;
    #1;
    compare();
    g_state = state; g_ms = mem_select; g_rnw = mem_read_not_write; g_m2r = mem_to_reg;
    g_pcw = pc_write; g_pcs = pc_source; g_rw = reg_write; g_aluop = alu_op;
    g_halt = halted; g_trap = trap;
    @(posedge clock);
    advance();
    @(negedge clock);
  endtask

  task automatic rst(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 1, 1, 0);
  endtask

  function automatic logic [4:0] pick();
    int k;
    k = $urandom % 100;
    return (k < 2) ? 5'h1F : (k < 4) ? 5'(5'h1C + $urandom % 3) : 5'($urandom % 28);
  endfunction

  initial begin
    int e[$];
    int mem_n, ib, db, dead_n;
    logic [4:0] op;
    bit im, dm;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 0);
      chk("t1_pcw", g_pcw, 1); chk("t1_pcs", g_pcs, 3); chk("t1_state", g_state, 0);
    end
    e = '{0, 1, 2, 4, 0};
    foreach (e[i]) begin
      cyc(1, 5'h05, 1, 1, 0);
      chk("t2_state", g_state, e[i]);
      if (i == 2) chk("t2_aluop", g_aluop, 5);
      chk("t2_regwr", g_rw, i == 3);
    end
    rst(1);
    e = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    mem_n = 0;
    foreach (e[i]) begin
      cyc(1, 5'h18, 1, !(i >= 3 && i <= 5), 0);
      chk("t3_ld_state", g_state, e[i]);
      mem_n += g_ms;
      if (e[i] == 3) chk("t3_ld_rnw", g_rnw, 1);
      if (e[i] == 4) chk("t3_ld_m2r", g_m2r, 1);
    end
    chk("t3_mem_cycles", mem_n, 4);
    rst(1);
    e = '{0, 1, 2, 3, 0};
    foreach (e[i]) begin
      cyc(1, 5'h19, 1, 1, 0);
      chk("t3_st_state", g_state, e[i]);
      if (i == 3) begin chk("t3_st_sel", g_ms, 1); chk("t3_st_rnw", g_rnw, 0); end
    end
    for (int z = 1; z >= 0; z--) begin
      rst(1);
      e = '{0, 1, 2, 0};
      foreach (e[i]) begin
        cyc(1, 5'h1A, 1, 1, 1'(z));
        chk("t4_state", g_state, e[i]);
        if (i == 2) begin chk("t4_pcw", g_pcw, z); chk("t4_pcs", g_pcs, z); end
      end
    end
    rst(1);
    for (int i = 0; i < 18; i++) begin
      cyc(1, 5'h05, 0, 1, 0);
      chk("t5_to_state", g_state, (i < 15) ? 0 : 6);
      if (i >= 15) chk("t5_trap", g_trap, 1);
    end
    rst(1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 5'h05, i == 14, 1, 0);
      chk("t5_edge_state", g_state, (i < 15) ? 0 : 1);
    end
    rst(1);
    for (int i = 0; i < 19; i++) begin
      cyc(1, 5'h19, 1, 0, 0);
      chk("t5_mem_to", g_state, (i < 3) ? i : (i < 18) ? 3 : 6);
    end
    rst(1);
    e = '{0, 1, 6, 6};
    foreach (e[i]) begin cyc(1, 5'h1C, 1, 1, 0); chk("t5_illegal", g_state, e[i]); end
    rst(1);
    e = '{0, 1, 5, 5};
    foreach (e[i]) begin cyc(1, 5'h1F, 1, 1, 0); chk("t5_halt", g_state, e[i]); end
    chk("t5_halted", g_halt, 1);
`ifdef MCC_PERF_CNT_EN
    rst(1);
    for (int i = 0; i < 40; i++) cyc(1, 5'h05, 1, 1, 0);
    chk("t6_instr_count", instr_count, 10);
    chk("t6_cycle_count", cycle_count, 40);
`endif
    rst(2);
    ib = 0; db = 0; dead_n = 0; op = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_dead == 0 && m_pos == 0) op = pick();
      if (ib > 0) begin im = 0; ib--; end
      else begin im = ($urandom % 4) != 0; if ($urandom % 60 == 0) ib = $urandom_range(12, 16); end
      if (db > 0) begin dm = 0; db--; end
      else begin dm = ($urandom % 4) != 0; if ($urandom % 40 == 0) db = $urandom_range(12, 16); end
      cyc(($urandom % 200 != 0) && dead_n < 4, op, im, dm, 1'($urandom % 2));
      dead_n = (m_dead != 0) ? dead_n + 1 : 0;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
